// File: rtl/bringup_levelshifter_scan.sv
// Bring-up UART pattern generator: one shared bit-timing engine drives per-channel ID frames.
// Optional macro BRINGUP_LVL_SEQ_EN appends a shared 8-bit sequence byte to every frame.
module bringup_levelshifter_scan #(
  parameter int          NUM_CHANNELS     = 16,
  parameter int          CLOCKS_PER_BAUD  = 104,
  parameter int          CLOCKS_PER_FRAME = 120000,
  parameter logic [7:0]  ID_BASE          = 8'h41
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    stagger,
  output logic [NUM_CHANNELS-1:0] tx_o,
  output logic [5:0]              active_o,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam int FW = $clog2(CLOCKS_PER_FRAME);
  localparam int BW = $clog2(CLOCKS_PER_BAUD);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                  r_state;
  logic [FW-1:0]           r_frameCnt;
  logic [BW-1:0]           r_baud;
  logic [2:0]              r_bitIdx;
  logic                    r_stag;
  logic [NUM_CHANNELS-1:0] r_tx;
  logic [5:0]              r_active;
  logic                    r_busy;
  logic                    r_frameDone;

  logic                    w_tick;
  logic                    w_baudEnd;
  logic                    w_lastByte;
  logic [2:0]              w_nextIdx;
  logic [NUM_CHANNELS-1:0] w_xmitNow;
  logic [NUM_CHANNELS-1:0] w_xmitTick;
  logic [NUM_CHANNELS-1:0] w_dataLine;

  assign w_tick    = enable && (r_frameCnt == FW'(CLOCKS_PER_FRAME - 1));
  assign w_baudEnd = (r_baud == BW'(CLOCKS_PER_BAUD - 1));
  assign w_nextIdx = (r_state == S_START) ? 3'd0 : r_bitIdx + 3'd1;

`ifdef BRINGUP_LVL_SEQ_EN
  logic [7:0] r_seq;
  logic       r_byteSel;

  assign w_lastByte = r_byteSel;

  // Byte selector alternates ID/sequence; sequence advances as the second byte completes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_seq     <= 8'd0;
      r_byteSel <= 1'b0;
    end else if (r_state == S_STOP && w_baudEnd) begin
      r_byteSel <= ~r_byteSel;
      if (r_byteSel) r_seq <= r_seq + 8'd1;
    end
  end
`else
  assign w_lastByte = 1'b1;
`endif

  always_comb begin : dataLines
    logic [7:0] chByte;
    chByte     = 8'h00;
    w_xmitNow  = '0;
    w_xmitTick = '0;
    w_dataLine = '1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_xmitNow[c]  = !r_stag  || (r_active == 6'(c));
      w_xmitTick[c] = !stagger || (r_active == 6'(c));
      chByte        = ID_BASE + 8'(c);
`ifdef BRINGUP_LVL_SEQ_EN
      if (r_byteSel) chByte = r_seq;
`endif
      w_dataLine[c] = w_xmitNow[c] ? chByte[w_nextIdx] : 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !enable) r_frameCnt <= '0;
    else if (w_tick)         r_frameCnt <= '0;
    else                     r_frameCnt <= r_frameCnt + FW'(1);
  end

  // Line values are loaded on the same edge the state enters each bit, so tx_o stays registered
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bitIdx    <= 3'd0;
      r_stag      <= 1'b0;
      r_tx        <= '1;
      r_active    <= 6'd0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (r_state != S_IDLE) r_baud <= w_baudEnd ? '0 : r_baud + BW'(1);
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_tick) begin
            r_state  <= S_START;
            r_busy   <= 1'b1;
            r_stag   <= stagger;
            r_bitIdx <= 3'd0;
            r_tx     <= ~w_xmitTick;
          end
        end
        S_START: begin
          if (w_baudEnd) begin
            r_state  <= S_DATA;
            r_bitIdx <= 3'd0;
            r_tx     <= w_dataLine;
          end
        end
        S_DATA: begin
          if (w_baudEnd) begin
            if (r_bitIdx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= '1;
            end else begin
              r_bitIdx <= w_nextIdx;
              r_tx     <= w_dataLine;
            end
          end
        end
        S_STOP: begin
          if (w_baudEnd) begin
            if (!w_lastByte) begin
              r_state <= S_START;
              r_tx    <= ~w_xmitNow;
            end else begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_frameDone <= 1'b1;
              if (r_stag)
                r_active <= (r_active == 6'(NUM_CHANNELS - 1)) ? 6'd0 : r_active + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_o         = r_tx;
  assign active_o     = r_active;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frameDone;

endmodule

// File: tb/tb_bringup_levelshifter_scan.sv
// Directed self-checking bench for bringup_levelshifter_scan (4 channels, 4 clocks/bit, 100-clock frames).
// Frames are checked bit-by-bit at mid-bit against a small UART frame model.
module tb_bringup_levelshifter_scan;

`ifdef BRINGUP_LVL_SEQ_EN
  localparam int FRAME_BITS = 20;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * 4;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       stagger;
  logic [3:0] tx_o;
  logic [5:0] active_o;
  logic       busy_o;
  logic       frame_done_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int framesDone  = 0;
  logic [9:0] hand43;

  bringup_levelshifter_scan #(
    .NUM_CHANNELS(4), .CLOCKS_PER_BAUD(4), .CLOCKS_PER_FRAME(100), .ID_BASE(8'h41)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .stagger(stagger),
    .tx_o(tx_o), .active_o(active_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic en, input logic stag);
    reset_n = rst_n;
    enable  = en;
    stagger = stag;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame bit k of a channel: start, 8 data LSB first, stop; bits 10..19 carry the sequence byte
  function automatic logic [3:0] expTx(input int k, input logic stag, input int act, input logic [7:0] seqByte);
    logic [7:0] b;
    logic       bitVal;
    int         j;
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (k < 10) begin b = 8'h41 + 8'(c); j = k; end
      else        begin b = seqByte;       j = k - 10; end
      if (j == 0)      bitVal = 1'b0;
      else if (j == 9) bitVal = 1'b1;
      else             bitVal = b[j-1];
      r[c] = (!stag || act == c) ? bitVal : 1'b1;
    end
    return r;
  endfunction

  task automatic waitStart(input string tag);
    int n;
    n = 0;
    while (busy_o !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_start"}, 32'(busy_o === 1'b1), 32'd1);
  endtask

  // Called at the first negedge in which the start bit is visible
  task automatic checkFrame(input string tag, input logic stag, input int act);
    int nextAct;
    checkOutput({tag, "_active"}, 32'(active_o), 32'(act));
    for (int k = 0; k < FRAME_BITS; k++) begin
      stepCycles((k == 0) ? 2 : 4);
      checkOutput($sformatf("%s_bit%0d", tag, k), 32'(tx_o), 32'(expTx(k, stag, act, 8'(framesDone))));
      if (!stag && k < 10)
        checkOutput($sformatf("%s_ch2bit%0d", tag, k), 32'(tx_o[2]), 32'(hand43[k]));
    end
    stepCycles(1);
    checkOutput({tag, "_doneEarly"}, 32'({busy_o, frame_done_o}), 32'b10);
    stepCycles(1);
    nextAct = stag ? (act + 1) % 4 : act;
    checkOutput({tag, "_done"}, 32'({busy_o, frame_done_o}), 32'b01);
    checkOutput({tag, "_idleTx"}, 32'(tx_o), 32'hF);
    checkOutput({tag, "_nextActive"}, 32'(active_o), 32'(nextAct));
    framesDone++;
    stepCycles(1);
    checkOutput({tag, "_donePulse"}, 32'(frame_done_o), 32'd0);
  endtask

  initial begin
    int  sawStart;
    int  sawDone;
    hand43 = 10'b1010000110;

    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(3);
    checkOutput("rst_tx", 32'(tx_o), 32'hF);
    checkOutput("rst_active", 32'(active_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(frame_done_o), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(99);
    checkOutput("t99_tx", 32'({busy_o, tx_o}), 32'h0F);
    stepCycles(1);
    checkOutput("t100_busy", 32'(busy_o), 32'd1);
    checkFrame("frame1", 1'b0, 0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int f = 0; f < 5; f++) begin
      waitStart($sformatf("stag%0d", f));
      checkFrame($sformatf("stag%0d", f), 1'b1, f % 4);
    end

    applyStimulus(1'b1, 1'b1, 1'b0);
    waitStart("endrop");
    stepCycles(10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(FRAME_CLKS - 10);
    checkOutput("endrop_done", 32'({busy_o, frame_done_o}), 32'b01);
    framesDone++;
    sawStart = 0;
    for (int i = 0; i < 300; i++) begin
      stepCycles(1);
      if (busy_o !== 1'b0 || tx_o !== 4'hF) sawStart++;
    end
    checkOutput("endrop_quiet", 32'(sawStart), 32'd0);
    checkOutput("endrop_active", 32'(active_o), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b0);
    waitStart("rstmid");
    stepCycles(13);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("rstmid_tx", 32'(tx_o), 32'hF);
    checkOutput("rstmid_busy", 32'(busy_o), 32'd0);
    checkOutput("rstmid_active", 32'(active_o), 32'd0);
    framesDone = 0;
    sawDone = 0;
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (frame_done_o !== 1'b0 || busy_o !== 1'b0) sawDone++;
      stepCycles(1);
    end
    checkOutput("rstmid_noDone", 32'(sawDone), 32'd0);

    waitStart("postrst");
    checkFrame("postrst", 1'b0, 0);
    waitStart("postrst2");
    checkFrame("postrst2", 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
